// File: rtl/video_axi_read_arbiter.sv
// Two-master AXI4 read arbiter: master 0 (video) has priority bounded by a starvation limit for master 1.
// AR is registered in a single slot; R beats route combinationally to the burst owner held in an in-order FIFO.
module video_axi_read_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_axi_ar_valid,
    output logic        m0_axi_ar_ready,
    input  logic [31:0] m0_axi_ar_payload_addr,
    input  logic [7:0]  m0_axi_ar_payload_len,
    input  logic [1:0]  m0_axi_ar_payload_burst,
    output logic        m0_axi_r_valid,
    input  logic        m0_axi_r_ready,
    output logic [31:0] m0_axi_r_payload_data,
    output logic        m0_axi_r_payload_last,

    input  logic        m1_axi_ar_valid,
    output logic        m1_axi_ar_ready,
    input  logic [31:0] m1_axi_ar_payload_addr,
    input  logic [7:0]  m1_axi_ar_payload_len,
    input  logic [1:0]  m1_axi_ar_payload_burst,
    output logic        m1_axi_r_valid,
    input  logic        m1_axi_r_ready,
    output logic [31:0] m1_axi_r_payload_data,
    output logic        m1_axi_r_payload_last,

    output logic        s_axi_ar_valid,
    input  logic        s_axi_ar_ready,
    output logic [31:0] s_axi_ar_payload_addr,
    output logic [7:0]  s_axi_ar_payload_len,
    output logic [1:0]  s_axi_ar_payload_burst,
    input  logic        s_axi_r_valid,
    output logic        s_axi_r_ready,
    input  logic [31:0] s_axi_r_payload_data,
    input  logic        s_axi_r_payload_last,

    output logic        protocol_err
);

    localparam int              PW         = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PW:0]     CNT_FULL   = (PW+1)'(MAX_OUTSTANDING);
    localparam logic [PW:0]     CNT_ONE    = (PW+1)'(1);
    localparam logic [PW-1:0]   PTR_ONE    = PW'(1);
    localparam logic [3:0]      STARVE_MAX = 4'(STARVE_LIMIT);

    logic                       slot_valid_q, slot_valid_d;
    logic [31:0]                slot_addr_q, slot_addr_d;
    logic [7:0]                 slot_len_q, slot_len_d;
    logic [1:0]                 slot_burst_q, slot_burst_d;
    logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
    logic [PW-1:0]              head_q, head_d;
    logic [PW-1:0]              tail_q, tail_d;
    logic [PW:0]                count_q, count_d;
    logic [3:0]                 starve_q, starve_d;
    logic                       err_q, err_d;

    logic fifo_empty, fifo_full, slot_free, can_accept;
    logic grant_0, grant_1, accept, owner_head, pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign slot_free  = ~slot_valid_q | s_axi_ar_ready;
    // reset_n gating keeps both ar_ready outputs low for the whole reset pulse
    assign can_accept = slot_free & ~fifo_full & reset_n;

    assign grant_1 = m1_axi_ar_valid & (~m0_axi_ar_valid | (starve_q == STARVE_MAX));
    assign grant_0 = m0_axi_ar_valid & ~grant_1;

    assign m0_axi_ar_ready = can_accept & grant_0;
    assign m1_axi_ar_ready = can_accept & grant_1;
    assign accept          = m0_axi_ar_ready | m1_axi_ar_ready;

    assign s_axi_ar_valid         = slot_valid_q;
    assign s_axi_ar_payload_addr  = slot_addr_q;
    assign s_axi_ar_payload_len   = slot_len_q;
    assign s_axi_ar_payload_burst = slot_burst_q;

    assign owner_head     = owner_q[head_q];
    assign s_axi_r_ready  = ~fifo_empty & (owner_head ? m1_axi_r_ready : m0_axi_r_ready);
    assign m0_axi_r_valid = s_axi_r_valid & ~fifo_empty & ~owner_head;
    assign m1_axi_r_valid = s_axi_r_valid & ~fifo_empty & owner_head;

    assign m0_axi_r_payload_data = s_axi_r_payload_data;
    assign m1_axi_r_payload_data = s_axi_r_payload_data;
    assign m0_axi_r_payload_last = s_axi_r_payload_last;
    assign m1_axi_r_payload_last = s_axi_r_payload_last;

    assign pop          = s_axi_r_valid & s_axi_r_ready & s_axi_r_payload_last;
    assign protocol_err = err_q;

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_addr_d  = slot_addr_q;
        slot_len_d   = slot_len_q;
        slot_burst_d = slot_burst_q;
        owner_d      = owner_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        starve_d     = starve_q;
        err_d        = err_q | (s_axi_r_valid & fifo_empty);

        if (accept) begin
            slot_valid_d    = 1'b1;
            slot_addr_d     = m1_axi_ar_ready ? m1_axi_ar_payload_addr  : m0_axi_ar_payload_addr;
            slot_len_d      = m1_axi_ar_ready ? m1_axi_ar_payload_len   : m0_axi_ar_payload_len;
            slot_burst_d    = m1_axi_ar_ready ? m1_axi_ar_payload_burst : m0_axi_ar_payload_burst;
            owner_d[tail_q] = m1_axi_ar_ready;
            tail_d          = tail_q + PTR_ONE;
        end else if (s_axi_ar_ready) begin
            slot_valid_d = 1'b0;
        end

        if (pop) begin
            head_d = head_q + PTR_ONE;
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // master 1 never waits more than STARVE_LIMIT consecutive master-0 grants
        if (~m1_axi_ar_valid | m1_axi_ar_ready) begin
            starve_d = 4'd0;
        end else if (m0_axi_ar_ready && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid_q <= 1'b0;
            slot_addr_q  <= '0;
            slot_len_q   <= '0;
            slot_burst_q <= '0;
            owner_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_addr_q  <= slot_addr_d;
            slot_len_q   <= slot_len_d;
            slot_burst_q <= slot_burst_d;
            owner_q      <= owner_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            err_q        <= err_d;
        end
    end

endmodule
